// File: rtl/sr_hyp_unit_if.sv
// sr_hyp_unit_if: start/operand/result bundle between the schoolRISCV
// control path and the hypotenuse coprocessor. Clock and reset stay plain
// ports on the module.
interface sr_hyp_unit_if;
  logic        start_i;
  logic [7:0]  a_bi;
  logic [7:0]  b_bi;
  logic [31:0] y_bo;
  logic        busy_o;

  // Core side: issues the request and consumes result/stall.
  modport master (
    output start_i, a_bi, b_bi,
    input  y_bo, busy_o
  );

  // Coprocessor side.
  modport slave (
    input  start_i, a_bi, b_bi,
    output y_bo, busy_o
  );
endinterface

// File: rtl/sr_hyp_unit.sv
// sr_hyp_unit: multi-cycle y = floor(sqrt(a*a + b*b)) for 8-bit unsigned
// operands. Squares are built by shift-add (8 cycles per operand), then a
// 9-iteration restoring square root produces the 9-bit result.
// Optional build macro SR_HYP_FAST_MUL_EN: both squares and their sum are
// formed in a single MUL cycle with combinational multipliers.
module sr_hyp_unit (
  input  logic               clk,
  input  logic               rst_n,
  sr_hyp_unit_if.slave       bus
);

`ifdef SR_HYP_FAST_MUL_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_MUL, ST_SQRT, ST_DONE
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_MUL_A, ST_MUL_B, ST_SQRT, ST_DONE
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [16:0] acc_q, acc_d;    // sum of squares, max 130050
  logic [3:0]  cnt_q, cnt_d;    // iteration counter
  logic [17:0] rad_q, rad_d;    // radicand, shifted left 2 bits per sqrt step
  logic [10:0] rem_q, rem_d;    // sqrt partial remainder
  logic [8:0]  root_q, root_d;  // sqrt partial root
  logic [8:0]  y_q, y_d;        // result register

  // Restoring sqrt datapath: bring down the next radicand bit pair and
  // try subtracting (4*root + 1).
  logic [12:0] rem_sh;
  logic [12:0] trial;
  logic        root_bit;
  logic [10:0] rem_sub;

  assign rem_sh   = {rem_q, rad_q[17:16]};
  assign trial    = {2'b00, root_q, 2'b01};
  assign root_bit = (rem_sh >= trial);
  // When the trial fits, the difference is bounded by 2*root (< 2048), so
  // the low 11 bits of the subtraction are the exact new remainder.
  assign rem_sub  = rem_sh[10:0] - trial[10:0];

`ifdef SR_HYP_FAST_MUL_EN
  // Whole sum of squares in one cycle.
  logic [16:0] sq_sum;
  assign sq_sum = ({9'd0, a_q} * {9'd0, a_q}) + ({9'd0, b_q} * {9'd0, b_q});
`else
  // One shift-add step: add (op << i) when bit i of op is set, where op is
  // both multiplicand and multiplier because we are squaring.
  logic [7:0]  mul_op;
  logic [16:0] part_prod;
  logic [16:0] acc_add;
  assign mul_op    = (state_q == ST_MUL_B) ? b_q : a_q;
  assign part_prod = mul_op[cnt_q[2:0]] ? ({9'd0, mul_op} << cnt_q[2:0]) : 17'd0;
  assign acc_add   = acc_q + part_prod;
`endif

  // Stall the PC from the start cycle through the last sqrt iteration; the
  // IDLE term is combinational so the PC holds in the very cycle of start.
  assign bus.busy_o = (state_q == ST_IDLE) ? bus.start_i : (state_q != ST_DONE);
  assign bus.y_bo   = {23'd0, y_q};

  // Next-state and datapath update for every FSM state.
  always_comb begin
    // NOTE: every variable gets a hold-value default first so no path through
    // the case statement leaves it unassigned, which would infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    y_d     = y_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          a_d   = bus.a_bi;
          b_d   = bus.b_bi;
          acc_d = 17'd0;
          cnt_d = 4'd0;
`ifdef SR_HYP_FAST_MUL_EN
          state_d = ST_MUL;
`else
          state_d = ST_MUL_A;
`endif
        end
      end

`ifdef SR_HYP_FAST_MUL_EN
      ST_MUL: begin
        acc_d   = sq_sum;
        rad_d   = {1'b0, sq_sum};
        rem_d   = 11'd0;
        root_d  = 9'd0;
        cnt_d   = 4'd0;
        state_d = ST_SQRT;
      end
`else
      ST_MUL_A: begin
        acc_d = acc_add;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          cnt_d   = 4'd0;
          state_d = ST_MUL_B;
        end
      end

      ST_MUL_B: begin
        acc_d = acc_add;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          rad_d   = {1'b0, acc_add};
          rem_d   = 11'd0;
          root_d  = 9'd0;
          cnt_d   = 4'd0;
          state_d = ST_SQRT;
        end
      end
`endif

      ST_SQRT: begin
        rem_d  = root_bit ? rem_sub : rem_sh[10:0];
        root_d = {root_q[7:0], root_bit};
        rad_d  = {rad_q[15:0], 2'b00};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd8) begin
          y_d     = {root_q[7:0], root_bit};
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Same HYP instruction is still decoded here, so start is ignored.
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any computation and clears the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      acc_q   <= 17'd0;
      cnt_q   <= 4'd0;
      rad_q   <= 18'd0;
      rem_q   <= 11'd0;
      root_q  <= 9'd0;
      y_q     <= 9'd0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values and
      // the update order inside this block cannot matter.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      y_q     <= y_d;
    end
  end

endmodule

// File: tb/tb_sr_hyp_unit.sv
// tb_sr_hyp_unit: directed and randomized checks of sr_hyp_unit against an
// arithmetic reference (largest r with r*r <= a*a + b*b). Build with
// SR_HYP_FAST_MUL_EN defined to check the single-cycle-multiply latency.
module tb_sr_hyp_unit;

`ifdef SR_HYP_FAST_MUL_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 26;
`endif
  localparam int RST_AT = (LAT > 12) ? 12 : 5;

  logic clk;
  logic rst_n;
  sr_hyp_unit_if bus ();

  int tests_run;
  int tests_failed;

  sr_hyp_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int ref_hyp(input int a, input int b);
    int s;
    int r;
    s = a * a + b * b;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One computation from a start pulse; optionally swaps operands to 200/200
  // at cycle chg_at. Checks busy length, result, upper zero bits and the
  // following IDLE cycle.
  task automatic do_calc(input logic [7:0] a, input logic [7:0] b,
                         input int chg_at, input string tag);
    int cycles;
    logic [31:0] exp;
    exp = ref_hyp(int'(a), int'(b));
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.a_bi    = a;
    bus.b_bi    = b;
    #1;
    check($sformatf("%s_busy_c0", tag), {31'd0, bus.busy_o}, 32'd1);
    cycles = 0;
    while (bus.busy_o === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
      bus.start_i = 1'b0;
      if (cycles == chg_at) begin
        bus.a_bi = 8'd200;
        bus.b_bi = 8'd200;
      end
      #1;
    end
    check($sformatf("%s_latency", tag), cycles, LAT);
    check($sformatf("%s_y", tag), bus.y_bo, exp);
    check($sformatf("%s_y_hi", tag), bus.y_bo >> 9, 32'd0);
    @(negedge clk);
    #1;
    check($sformatf("%s_idle_busy", tag), {31'd0, bus.busy_o}, 32'd0);
    check($sformatf("%s_y_hold", tag), bus.y_bo, exp);
  endtask

  initial begin
    int cycles;
    logic [7:0] ra;
    logic [7:0] rb;
    tests_run    = 0;
    tests_failed = 0;
    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    bus.a_bi    = 8'd0;
    bus.b_bi    = 8'd0;

    // Reset state.
    #12;
    check("rst_y", bus.y_bo, 32'd0);
    check("rst_busy_lo", {31'd0, bus.busy_o}, 32'd0);
    bus.start_i = 1'b1;
    #1;
    check("rst_busy_follows_start", {31'd0, bus.busy_o}, 32'd1);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operand set.
    do_calc(8'd3,   8'd4,   -1, "hyp_3_4");
    do_calc(8'd0,   8'd0,   -1, "hyp_0_0");
    do_calc(8'd1,   8'd1,   -1, "hyp_1_1");
    do_calc(8'd5,   8'd12,  -1, "hyp_5_12");
    do_calc(8'd255, 8'd255, -1, "hyp_255_255");
    do_calc(8'd255, 8'd0,   -1, "hyp_255_0");

    // Operands changed mid-operation have no effect.
    do_calc(8'd3, 8'd4, 5, "opchg_3_4");

    // Start held high across completion: no restart in DONE, re-accept in IDLE.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.a_bi    = 8'd6;
    bus.b_bi    = 8'd8;
    #1;
    cycles = 0;
    while (bus.busy_o === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
      #1;
    end
    check("hold_latency", cycles, LAT);
    check("hold_done_y", bus.y_bo, 32'd10);
    check("hold_done_busy", {31'd0, bus.busy_o}, 32'd0);
    @(negedge clk);
    #1;
    check("hold_reaccept_busy", {31'd0, bus.busy_o}, 32'd1);
    cycles = 0;
    while (bus.busy_o === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
      #1;
    end
    bus.start_i = 1'b0;
    check("hold_restart_latency", cycles, LAT);
    check("hold_restart_y", bus.y_bo, 32'd10);
    @(negedge clk);
    #1;
    check("hold_after_idle_busy", {31'd0, bus.busy_o}, 32'd0);

    // Asynchronous reset mid-computation.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.a_bi    = 8'd255;
    bus.b_bi    = 8'd255;
    for (int k = 1; k <= RST_AT; k++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    #1;
    check("midrst_busy_before", {31'd0, bus.busy_o}, 32'd1);
    check("midrst_y_before", bus.y_bo, 32'd10);
    rst_n = 1'b0;
    #1;
    check("midrst_y", bus.y_bo, 32'd0);
    check("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
    bus.start_i = 1'b1;
    #1;
    check("midrst_busy_start", {31'd0, bus.busy_o}, 32'd1);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_calc(8'd7, 8'd24, -1, "after_rst");

    // Randomized operands against the reference.
    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      do_calc(ra, rb, -1, $sformatf("rand%0d_%0d_%0d", i, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
